// File: rtl/mac_cyv_pkg.sv
// Shared constants and types for the half-precision MAC column.
// Binary16 field widths, exponent bias, infinity encodings and half_t.
package mac_cyv_pkg;

    localparam int HALF_EXP_BITS  = 5;
    localparam int HALF_MANT_BITS = 10;
    localparam int HALF_EXP_BIAS  = 15;

    localparam logic [15:0] HALF_POS_INF = 16'h7C00;
    localparam logic [15:0] HALF_NEG_INF = 16'hFC00;

    typedef struct packed {
        logic                      sign;
        logic [HALF_EXP_BITS-1:0]  exp;
        logic [HALF_MANT_BITS-1:0] mant;
    } half_t;

endpackage

// File: rtl/mac_cyv_fix2half_out_lod.sv
// Combinational leading-one detector of parameterised width.
// Ports: vec (input word), idx (index of highest set bit), zero (vec == 0).
module mac_cyv_lead_one_det #(
    parameter  int WIDTH = 33,
    localparam int IW    = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] vec,
    output logic [IW-1:0]    idx,
    output logic             zero
);

    // Ascending scan: the last set bit seen is the most significant one.
    always_comb begin
        idx  = '0;
        zero = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            if (vec[i]) begin
                idx  = IW'(i);
                zero = 1'b0;
            end
        end
    end

endmodule

// File: rtl/mac_cyv_fix2half_out.sv
// Fixed-point accumulator to IEEE-754 binary16 converter, 3-stage pipeline.
// Ports: clk, areset (sync, active-high), in_data/in_valid/in_ready,
//        out_half/out_valid/out_ready, out_overflow (saturated to +-inf).
// Optional build macro MAC_CYV_FIX2HALF_RELU_EN: negative inputs yield 0.
module mac_cyv_fix2half_out
    import mac_cyv_pkg::*;
#(
    parameter int FIXEDSIZE = 32,
    parameter int FRAC_BITS = 20
) (
    input  logic                 clk,
    input  logic                 areset,
    input  logic [FIXEDSIZE-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [15:0]          out_half,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_overflow
);

    localparam int AW = FIXEDSIZE + 1;
    localparam int IW = $clog2(AW);

    localparam logic signed [9:0] EXP_OFS = 10'(HALF_EXP_BIAS - FRAC_BITS);

    // ---------------- pipeline control ----------------
    logic s1_valid, s2_valid, s3_valid;
    logic s1_en, s2_en, s3_en;

    // A stage loads when it is empty or its content moves on this edge.
    assign s3_en    = !s3_valid || out_ready;
    assign s2_en    = !s2_valid || s3_en;
    assign s1_en    = !s1_valid || s2_en;
    assign in_ready = s1_en;
    assign out_valid = s3_valid;

    always_ff @(posedge clk) begin
        if (areset) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s3_valid <= 1'b0;
        end else begin
            if (s1_en) s1_valid <= in_valid;
            if (s2_en) s2_valid <= s1_valid;
            if (s3_en) s3_valid <= s2_valid;
        end
    end

    // ---------------- stage 1: sign / magnitude ----------------
    logic          in_neg;
    logic [AW-1:0] in_ext;
    logic [AW-1:0] abs_next;
    logic          sign_next;

    assign in_neg = in_data[FIXEDSIZE-1];
    assign in_ext = {in_neg, in_data};

`ifdef MAC_CYV_FIX2HALF_RELU_EN
    // Fused ReLU: negative values collapse to a zero magnitude.
    assign abs_next  = in_neg ? '0 : in_ext;
    assign sign_next = 1'b0;
`else
    // One extra bit keeps the magnitude of the most negative input exact.
    assign abs_next  = in_neg ? (~in_ext + AW'(1)) : in_ext;
    assign sign_next = in_neg;
`endif

    logic          s1_sign;
    logic          s1_zero;
    logic [AW-1:0] s1_abs;

    always_ff @(posedge clk) begin
        if (s1_en && in_valid) begin
            s1_sign <= sign_next;
            s1_zero <= (abs_next == '0);
            s1_abs  <= abs_next;
        end
    end

    // ---------------- stage 2: normalise ----------------
    logic [IW-1:0] lod_idx;
    logic          lod_zero;
    logic [IW-1:0] lsh;
    logic [AW-1:0] norm_next;

    mac_cyv_lead_one_det #(
        .WIDTH (AW)
    ) u_lod (
        .vec  (s1_abs),
        .idx  (lod_idx),
        .zero (lod_zero)
    );

    assign lsh       = IW'(AW - 1) - lod_idx;
    assign norm_next = lod_zero ? '0 : (s1_abs << lsh);

    logic          s2_sign;
    logic          s2_zero;
    logic [IW-1:0] s2_p;
    logic [AW-1:0] s2_norm;

    always_ff @(posedge clk) begin
        if (s2_en && s1_valid) begin
            s2_sign <= s1_sign;
            s2_zero <= s1_zero;
            s2_p    <= lod_idx;
            s2_norm <= norm_next;
        end
    end

    // ---------------- stage 3: round and pack ----------------
    logic signed [9:0] exp_b;
    logic signed [9:0] exp_r;
    logic [9:0]        mant_t;
    logic              guard;
    logic              sticky;
    logic              rnd;
    logic [10:0]       mant_r;
    logic [9:0]        sub_sh;
    logic [9:0]        mant_s;
    logic              is_zero;
    logic              is_norm;
    half_t             res;
    logic              res_ovf;

    always_comb begin
        exp_b  = $signed(10'(s2_p)) + EXP_OFS;
        mant_t = s2_norm[AW-2 -: 10];
        guard  = s2_norm[AW-12];
        sticky = |s2_norm[AW-13:0];
        rnd    = guard && (sticky || mant_t[0]);
        mant_r = {1'b0, mant_t} + {10'd0, rnd};
        // A mantissa carry bumps the exponent; mant_r[9:0] is then zero.
        exp_r  = exp_b + $signed({9'd0, mant_r[10]});
        // Subnormal field is abs * 2^(24-FRAC_BITS); the leading one sits
        // at bit exp_b+9, so shifting norm right lands it there. This is
        // exact for FRAC_BITS <= 24, so no bits are lost to rounding.
        sub_sh = 10'(AW - 10) - $unsigned(exp_b);
        mant_s = 10'(s2_norm >> sub_sh);
        // No leading one at the MSB means the magnitude was zero.
        is_zero = s2_zero || !s2_norm[AW-1];
        is_norm = exp_b > 10'sd0;

        res     = '0;
        res_ovf = 1'b0;
        unique case (1'b1)
            is_zero: begin
                res     = '0;
                res_ovf = 1'b0;
            end
            (!is_zero && is_norm): begin
                if (exp_r >= 10'sd31) begin
                    res     = s2_sign ? HALF_NEG_INF : HALF_POS_INF;
                    res_ovf = 1'b1;
                end else begin
                    res.sign = s2_sign;
                    res.exp  = 5'(exp_r);
                    res.mant = mant_r[9:0];
                end
            end
            (!is_zero && !is_norm): begin
                res.sign = s2_sign;
                res.exp  = '0;
                res.mant = mant_s;
            end
            default: begin
                res     = '0;
                res_ovf = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (areset) begin
            out_half     <= 16'h0000;
            out_overflow <= 1'b0;
        end else if (s3_en && s2_valid) begin
            out_half     <= res;
            out_overflow <= res_ovf;
        end
    end

endmodule

// File: tb/tb_mac_cyv_fix2half_out.sv
// Directed self-checking bench for mac_cyv_fix2half_out.
// Two instances: default FRAC_BITS=20 and FRAC_BITS=4 for overflow cases.
module tb_mac_cyv_fix2half_out;

    logic        clk = 1'b0;
    logic        areset;
    logic [31:0] in_data;
    logic        in_valid;
    logic        out_ready;

    logic        in_ready_a, out_valid_a, out_overflow_a;
    logic [15:0] out_half_a;
    logic        in_ready_b, out_valid_b, out_overflow_b;
    logic [15:0] out_half_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

`ifdef MAC_CYV_FIX2HALF_RELU_EN
    localparam logic [15:0] EXP_NEG1   = 16'h0000;
    localparam logic [15:0] EXP_MOSTNEG = 16'h0000;
    localparam logic [15:0] EXP_B_NEG  = 16'h0000;
    localparam logic [31:0] EXP_B_NOVF = 32'd0;
`else
    localparam logic [15:0] EXP_NEG1   = 16'hBC00;
    localparam logic [15:0] EXP_MOSTNEG = 16'hE800;
    localparam logic [15:0] EXP_B_NEG  = 16'hFC00;
    localparam logic [31:0] EXP_B_NOVF = 32'd1;
`endif

    mac_cyv_fix2half_out u_dut_a (
        .clk          (clk),
        .areset       (areset),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready_a),
        .out_half     (out_half_a),
        .out_valid    (out_valid_a),
        .out_ready    (out_ready),
        .out_overflow (out_overflow_a)
    );

    mac_cyv_fix2half_out #(
        .FRAC_BITS (4)
    ) u_dut_b (
        .clk          (clk),
        .areset       (areset),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready_b),
        .out_half     (out_half_b),
        .out_valid    (out_valid_b),
        .out_ready    (out_ready),
        .out_overflow (out_overflow_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Entered and left at posedge+1. One transfer, then exactly 3 cycles
    // until out_valid with out_ready held high.
    task automatic run_vec(input logic [31:0] d,
                           output logic [15:0] ha, output logic oa,
                           output logic [15:0] hb, output logic ob,
                           output logic lat_ok);
        logic rdy, v1, v2, v3;
        in_data  = d;
        in_valid = 1'b1;
        @(negedge clk);
        rdy = in_ready_a & in_ready_b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        v1 = out_valid_a | out_valid_b;
        @(posedge clk); #1;
        @(negedge clk);
        v2 = out_valid_a | out_valid_b;
        @(posedge clk); #1;
        @(negedge clk);
        v3 = out_valid_a & out_valid_b;
        ha = out_half_a;
        oa = out_overflow_a;
        hb = out_half_b;
        ob = out_overflow_b;
        @(posedge clk); #1;
        lat_ok = rdy & !v1 & !v2 & v3;
    endtask

    logic [15:0] ha, hb;
    logic        oa, ob, lat;
    logic [31:0] bp_items [5];
    logic [15:0] bp_exp   [5];
    logic [15:0] outs     [5];
    int          k, got;
    logic        seen;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bp_items = '{32'h00100000, 32'h00200000, 32'h00300000,
                     32'h00400000, 32'h00500000};
        bp_exp   = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400, 16'h4500};
        outs     = '{default: 16'h0};

        areset    = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 areset = 1'b0;

        @(negedge clk);
        chk("rst_half", {16'd0, out_half_a}, 32'h0);
        chk("rst_valid", {31'd0, out_valid_a}, 32'h0);
        chk("rst_ovf", {31'd0, out_overflow_a}, 32'h0);
        chk("rst_ready", {31'd0, in_ready_a}, 32'h1);
        @(posedge clk); #1;

        run_vec(32'h00100000, ha, oa, hb, ob, lat);
        chk("one_half", {16'd0, ha}, 32'h3C00);
        chk("one_lat", {31'd0, lat}, 32'h1);

        run_vec(32'hFFF00000, ha, oa, hb, ob, lat);
        chk("neg1_half", {16'd0, ha}, {16'd0, EXP_NEG1});
        chk("neg1_lat", {31'd0, lat}, 32'h1);

        run_vec(32'h00000000, ha, oa, hb, ob, lat);
        chk("zero_half", {16'd0, ha}, 32'h0);
        chk("zero_ovf", {31'd0, oa}, 32'h0);
        chk("zero_lat", {31'd0, lat}, 32'h1);

        run_vec(32'h80000000, ha, oa, hb, ob, lat);
        chk("mostneg_half", {16'd0, ha}, {16'd0, EXP_MOSTNEG});
        chk("mostneg_ovf", {31'd0, oa}, 32'h0);

        run_vec(32'h00000001, ha, oa, hb, ob, lat);
        chk("subn_half", {16'd0, ha}, 32'h0010);
        chk("subn_ovf", {31'd0, oa}, 32'h0);

        run_vec(32'h7FFFFFFF, ha, oa, hb, ob, lat);
        chk("maxpos_half", {16'd0, ha}, 32'h6800);
        chk("maxpos_ovf", {31'd0, oa}, 32'h0);

        run_vec(32'h00100200, ha, oa, hb, ob, lat);
        chk("rne_tie_even", {16'd0, ha}, 32'h3C00);

        run_vec(32'h00100600, ha, oa, hb, ob, lat);
        chk("rne_tie_up", {16'd0, ha}, 32'h3C02);

        run_vec(32'h00100201, ha, oa, hb, ob, lat);
        chk("rne_above", {16'd0, ha}, 32'h3C01);

        run_vec(32'h00100000, ha, oa, hb, ob, lat);
        chk("ovf_pos_half", {16'd0, hb}, 32'h7C00);
        chk("ovf_pos_flag", {31'd0, ob}, 32'h1);

        run_vec(32'hFFF00000, ha, oa, hb, ob, lat);
        chk("ovf_neg_half", {16'd0, hb}, {16'd0, EXP_B_NEG});
        chk("ovf_neg_flag", {31'd0, ob}, EXP_B_NOVF);

        // Backpressure: consumer stalled while 5 inputs are offered.
        out_ready = 1'b0;
        k = 0;
        for (int c = 0; c < 6; c++) begin
            in_valid = 1'b1;
            in_data  = bp_items[k];
            @(negedge clk);
            if (in_ready_a) k++;
            @(posedge clk); #1;
        end
        chk("bp_accepted", k, 32'd3);
        @(negedge clk);
        chk("bp_ready_low", {31'd0, in_ready_a}, 32'h0);
        chk("bp_out_valid", {31'd0, out_valid_a}, 32'h1);
        for (int c = 0; c < 3; c++) begin
            chk("bp_hold", {16'd0, out_half_a}, 32'h3C00);
            @(negedge clk);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 30 && got < 5; c++) begin
            in_valid = (k < 5);
            if (k < 5) in_data = bp_items[k];
            @(negedge clk);
            if (out_valid_a) begin
                outs[got] = out_half_a;
                got++;
            end
            if (in_valid && in_ready_a) k++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("bp_count", got, 32'd5);
        for (int i = 0; i < 5; i++)
            chk($sformatf("bp_out%0d", i), {16'd0, outs[i]},
                {16'd0, bp_exp[i]});
        repeat (4) @(posedge clk);
        #1;

        // Reset with two items in flight.
        in_data  = 32'h00100000;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_data  = 32'h00200000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        areset   = 1'b1;
        @(posedge clk); #1;
        areset   = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", {31'd0, out_valid_a}, 32'h0);
        chk("mid_rst_half", {16'd0, out_half_a}, 32'h0);
        chk("mid_rst_ready", {31'd0, in_ready_a}, 32'h1);
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (out_valid_a || out_valid_b) seen = 1'b1;
        end
        chk("mid_rst_no_stale", {31'd0, seen}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
